uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter: next generation of the single-byte sender.
//  Adds a FIFO with valid/ready handshake, configurable baud, data width and
//  stop bits, plus optional parity. Sits between core logic and the board TX pin.
//  Frames go out back-to-back while the FIFO is non-empty.
// PARAMETERS
//  CLK_FREQ    100_000_000  input clock frequency, Hz
//  BAUD        9600         line rate; DIV = CLK_FREQ/BAUD (truncating), DIV>=2
//  DATA_BITS   8            payload bits per frame, 5..8
//  STOP_BITS   1            stop bits, 1 or 2
//  FIFO_DEPTH  4            entries; power of two, >=2
//  PARITY_ODD  0            0 = even, 1 = odd parity (used only with the macro)
// PORTS
//  clk         in   1                        system clock, rising edge
//  rst         in   1                        asynchronous reset, active high
//  valid       in   1                        write request
//  data        in   DATA_BITS                payload; sampled when valid&&ready
//  ready       out  1                        FIFO can accept; = !full (combinational)
//  dout        out  1                        serial line, idle high, registered
//  busy        out  1                        high while state != IDLE
//  fifo_count  out  $clog2(FIFO_DEPTH)+1     entries currently stored
// BEHAVIOUR
//  - Reset (async, any time): dout=1, busy=0, FIFO emptied, fifo_count=0, ready=1,
//    state=IDLE, baud counter=0. Reset mid-frame aborts it; no partial resume.
//  - Push on edge with valid&&ready. ready ignores a same-cycle pop: full => reject.
//  - Baud counter counts 0..DIV-1 outside IDLE; tick at DIV-1; held at 0 in IDLE.
//    Every line bit lasts exactly DIV clocks.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//    IDLE: if FIFO non-empty, pop head into shift reg, go START, dout<=0 same edge.
//    START: on tick -> DATA, bit index=0.
//    DATA: dout = shift[idx], LSB first; on tick idx++; after idx=DATA_BITS-1
//      -> PARITY (macro) else STOP.
//    STOP: dout=1 for STOP_BITS*DIV clocks; then pop+START if non-empty
//      (no idle gap), else IDLE.
//  - dout registered, updated on the edge of each state/bit change.
//  - Latency: push at edge N into empty FIFO while IDLE -> pop at N+1, dout low
//    after N+1. fifo_count holds on simultaneous push+pop.
//  - Frame = (1+DATA_BITS+P+STOP_BITS)*DIV clocks, P = 1 with parity else 0.
//  - Unused upper data bits never transmitted; pointers wrap mod FIFO_DEPTH.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state after DATA, one bit-time,
//    dout = ^payload ^ PARITY_ODD.
//  Undefined: no PARITY state, PARITY_ODD ignored, no parity logic built.
// TESTING (sim params CLK_FREQ=16, BAUD=1 -> DIV=16, FIFO_DEPTH=4)
//  1. Push 8'hA5, 8N1 -> dout 0x16, then 1,0,1,0,0,1,0,1 x16 each, 1 x16;
//     busy high 160 clocks.
//  2. valid high 6 consecutive cycles, idle line -> 5 accepted, ready=0 with
//     fifo_count=4, 6th dropped; 5 frames back-to-back, no high gap beyond stop.
//  3. rst pulse mid-DATA -> dout=1 immediately, busy=0, fifo_count=0; next
//     push 8'h3C sent correctly.
//  4. DATA_BITS=7, STOP_BITS=2, push 7'h55 -> 0,1,0,1,0,1,0,1,1,1: 10 bit-times.
//  5. Macro on, push 8'hA5: PARITY_ODD=0 -> parity 0; PARITY_ODD=1 -> parity 1;
//     11 bit-times. Macro off -> 10 bit-times.
//  6. Push during STOP of previous frame -> START follows last stop bit on very
//     next clock; busy stays high across both frames.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between core logic and uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, frames sent back-to-back while data is queued.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               tx,
    output logic                        dout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_fifo: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 stop_last;

    assign full      = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign tx.ready  = ~full;
    assign push      = tx.valid && ~full;
    assign tick      = (cnt == CNT_W'(DIV - 1));
    assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
    // Pop from IDLE, or at the end of the last stop bit so the next START has no gap.
    assign pop = (fifo_count != '0) &&
                 ((state == S_IDLE) || ((state == S_STOP) && tick && stop_last));

    // Storage has no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx.data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      parity <= 1'b0;
        else if (pop) parity <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            dout     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (state == S_IDLE || tick) cnt <= '0;
            else                         cnt <= cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                        dout  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state <= S_DATA;
                        idx   <= '0;
                        dout  <= shift[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            dout  <= parity;
`else
                            state    <= S_STOP;
                            stop_idx <= 1'b0;
                            dout     <= 1'b1;
`endif
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            shift <= shift >> 1;
                            dout  <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        dout     <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (!stop_last) begin
                            stop_idx <= 1'b1;
                        end else if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                            dout  <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    dout  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
